// File: rtl/tlp_rx_filter.sv
// Store-and-forward filter between the PCIe RX stream and the PIO engine: only whole,
// error-free, BAR0-hit posted memory writes of bounded length are ever released.
module tlp_rx_filter #(
  parameter int DEPTH_LOG2 = 9,
  parameter int MAX_LEN_DW = 32
) (
  input  logic        user_clk,
  input  logic        user_reset,
  input  logic [63:0] m_axis_rx_tdata,
  input  logic [7:0]  m_axis_rx_tkeep,
  input  logic        m_axis_rx_tlast,
  input  logic        m_axis_rx_tvalid,
  output logic        m_axis_rx_tready,
  input  logic [21:0] m_axis_rx_tuser,
  output logic [63:0] out_tdata,
  output logic [7:0]  out_tkeep,
  output logic        out_tlast,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [15:0] pass_cnt,
  output logic [15:0] drop_cnt
);

  localparam int MAX_BEATS = (MAX_LEN_DW + 5) / 2;
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int PW        = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_W     = PW'(DEPTH);
  localparam logic [PW-1:0] MAX_BEATS_W = PW'(MAX_BEATS);
  localparam logic [PW-1:0] PTR_ONE     = PW'(1);
  localparam logic [9:0]    MAX_LEN_W   = 10'(MAX_LEN_DW);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STORE   = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  // A new TLP may only start when a worst-case TLP is guaranteed to fit.
  function automatic logic free_ok(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
    logic [PW-1:0] used;
    used = wr - rd;
    return (DEPTH_W - used) >= MAX_BEATS_W;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic hdr_keep(input logic [31:0] dw0, input logic [21:0] user);
    return ((dw0[30:29] == 2'b10) || (dw0[30:29] == 2'b11)) &&
           (dw0[28:24] == 5'b00000) && user[2] && !user[1] &&
           (dw0[9:0] != 10'd0) && (dw0[9:0] <= MAX_LEN_W);
  endfunction

  state_t        state_r;
  logic [PW-1:0] wr_ptr_r, commit_ptr_r, rd_ptr_r, fetch_ptr_r;
  logic          rx_ready_r;
  logic [72:0]   out_beat_r;
  logic          out_valid_r;
  logic [15:0]   pass_cnt_r, drop_cnt_r;
  logic [72:0]   mem_r [DEPTH];

  logic          rx_hs_s, err_s, keep_s, wr_en_s, out_hs_s, fetch_ok_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic          unused_s;

  assign rx_hs_s      = m_axis_rx_tvalid && rx_ready_r;
  assign err_s        = m_axis_rx_tuser[1];
  assign keep_s       = hdr_keep(m_axis_rx_tdata[31:0], m_axis_rx_tuser);
  assign out_hs_s     = out_valid_r && out_tready;
  assign rd_ptr_nxt_s = out_hs_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
  assign fetch_ok_s   = (fetch_ptr_r != commit_ptr_r) && (!out_valid_r || out_tready);
  assign unused_s     = ^{m_axis_rx_tuser[21:3], m_axis_rx_tuser[0]};

  assign m_axis_rx_tready = rx_ready_r;
  assign out_tdata  = out_beat_r[63:0];
  assign out_tkeep  = out_beat_r[71:64];
  assign out_tlast  = out_beat_r[72];
  assign out_tvalid = out_valid_r;
  assign pass_cnt   = pass_cnt_r;
  assign drop_cnt   = drop_cnt_r;

  // Beat write enable: SOP of a kept TLP, or any clean beat while storing.
  always_comb begin
    wr_en_s = 1'b0;
    if (rx_hs_s) begin
      case (state_r)
        ST_IDLE:  wr_en_s = keep_s;
        ST_STORE: wr_en_s = !err_s;
        default:  wr_en_s = 1'b0;
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Beat storage.
  always_ff @(posedge user_clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= {m_axis_rx_tlast, m_axis_rx_tkeep, m_axis_rx_tdata};
    end
  end

  // Input FSM: store/discard decision, rollback on err_fwd, commit, counters and tready.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= '0;
      commit_ptr_r <= '0;
      rx_ready_r   <= 1'b0;
      pass_cnt_r   <= 16'd0;
      drop_cnt_r   <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rx_hs_s && keep_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (m_axis_rx_tlast) begin
              commit_ptr_r <= wr_ptr_r + PTR_ONE;
              pass_cnt_r   <= sat_inc(pass_cnt_r);
              state_r      <= ST_IDLE;
              rx_ready_r   <= free_ok(wr_ptr_r + PTR_ONE, rd_ptr_nxt_s);
            end else begin
              state_r    <= ST_STORE;
              rx_ready_r <= 1'b1;
            end
          end else if (rx_hs_s) begin
            if (m_axis_rx_tlast) begin
              drop_cnt_r <= sat_inc(drop_cnt_r);
              state_r    <= ST_IDLE;
              rx_ready_r <= free_ok(wr_ptr_r, rd_ptr_nxt_s);
            end else begin
              state_r    <= ST_DISCARD;
              rx_ready_r <= 1'b1;
            end
          end else begin
            rx_ready_r <= free_ok(wr_ptr_r, rd_ptr_nxt_s);
          end
        end
        ST_STORE: begin
          if (rx_hs_s && err_s) begin
            wr_ptr_r <= commit_ptr_r;
            if (m_axis_rx_tlast) begin
              drop_cnt_r <= sat_inc(drop_cnt_r);
              state_r    <= ST_IDLE;
              rx_ready_r <= free_ok(commit_ptr_r, rd_ptr_nxt_s);
            end else begin
              state_r    <= ST_DISCARD;
              rx_ready_r <= 1'b1;
            end
          end else if (rx_hs_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (m_axis_rx_tlast) begin
              commit_ptr_r <= wr_ptr_r + PTR_ONE;
              pass_cnt_r   <= sat_inc(pass_cnt_r);
              state_r      <= ST_IDLE;
              rx_ready_r   <= free_ok(wr_ptr_r + PTR_ONE, rd_ptr_nxt_s);
            end else begin
              state_r    <= ST_STORE;
              rx_ready_r <= 1'b1;
            end
          end else begin
            rx_ready_r <= 1'b1;
          end
        end
        ST_DISCARD: begin
          if (rx_hs_s && m_axis_rx_tlast) begin
            drop_cnt_r <= sat_inc(drop_cnt_r);
            state_r    <= ST_IDLE;
            rx_ready_r <= free_ok(wr_ptr_r, rd_ptr_nxt_s);
          end else begin
            rx_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          wr_ptr_r   <= commit_ptr_r;
          rx_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Consumed pointer: space is released only once the PIO has taken the beat.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      rd_ptr_r <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
    end
  end

  // Output register fed by a registered RAM read of committed beats only.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      fetch_ptr_r <= '0;
      out_beat_r  <= 73'd0;
      out_valid_r <= 1'b0;
    end else if (fetch_ok_s) begin
      out_beat_r  <= mem_r[fetch_ptr_r[DEPTH_LOG2-1:0]];
      out_valid_r <= 1'b1;
      fetch_ptr_r <= fetch_ptr_r + PTR_ONE;
    end else if (out_hs_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: doc/tlp_rx_filter.md
# tlp_rx_filter

Store-and-forward filter between the PCIe core's 64-bit AXI4-Stream RX interface (`m_axis_rx_*`) and the PIO RX engine. It passes only posted Memory Write TLPs (MWr32/MWr64) that hit BAR0 and are no longer than a configured size. Every other TLP is discarded. A packet reaches the PIO only after its last beat has arrived without a forwarded-error flag, so the PIO never sees a partial or poisoned write.

## Interface
- `DEPTH_LOG2`, default 9: FIFO depth is 2^DEPTH_LOG2 beats of 73 bits ({tlast, tkeep, tdata}).
- `MAX_LEN_DW`, default 32: largest accepted payload in DW. `MAX_BEATS = (MAX_LEN_DW+5)/2` (integer division); this is 18 at the default.
- `user_clk`  in  1  clock; all logic runs in this domain.
- `user_reset`  in  1  synchronous, active-high reset.
- `m_axis_rx_tdata`  in  64  RX beat data. Header DW0 is in bits [31:0] of the first beat.
- `m_axis_rx_tkeep`  in  8  byte enables; 8'hFF or 8'h0F.
- `m_axis_rx_tlast`  in  1  last beat of the TLP.
- `m_axis_rx_tvalid`  in  1  beat valid.
- `m_axis_rx_tready`  out  1  beat accepted when high together with tvalid.
- `m_axis_rx_tuser`  in  22  bit 1 is err_fwd; bits [8:2] are the BAR-hit vector, with bit 2 = BAR0.
- `out_tdata`  out  64, `out_tkeep`  out  8, `out_tlast`  out  1, `out_tvalid`  out  1: filtered stream toward the PIO.
- `out_tready`  in  1  downstream accept.
- `pass_cnt`  out  16  number of TLPs committed; saturates at 16'hFFFF.
- `drop_cnt`  out  16  number of TLPs discarded; saturates at 16'hFFFF.

## Operation
- **Input FSM states:** IDLE (expecting SOP), STORE (keeping the current TLP), DISCARD (consuming and ignoring it).
- **Decision on the SOP beat**, taken from DW0 = tdata[31:0]. A TLP is kept only if all of the following hold:
  - fmt[30:29] ∈ {2'b10, 2'b11}
  - type[28:24] == 5'b00000
  - tuser[2] == 1
  - length[9:0] != 0 and length ≤ MAX_LEN_DW. A length of 0 means 1024 DW and is therefore dropped.
  - tuser[1] == 0
- **Kept TLP:** the SOP beat is written at `wr_ptr` and the FSM goes to STORE. A single-beat TLP with tlast is committed immediately.
- **Not kept:** the FSM goes to DISCARD (or stays in IDLE if tlast is set on that beat). No beats are written. `drop_cnt` increments when the TLP's tlast is accepted.
- **STORE:** every accepted beat is written and `wr_ptr` advances.
  - On tlast with err_fwd == 0: `commit_ptr <= wr_ptr+1`, `pass_cnt` increments, FSM goes to IDLE.
  - Any beat with tuser[1] == 1: `wr_ptr` rolls back to `commit_ptr`. If that beat has tlast, `drop_cnt` increments and the FSM goes to IDLE; otherwise the FSM goes to DISCARD.
- **Input tready rule:**
  - In IDLE, `m_axis_rx_tready = (free ≥ MAX_BEATS)`, where `free = 2^DEPTH_LOG2 − (wr_ptr − rd_ptr)`.
  - In STORE and DISCARD, tready is 1 unconditionally. Space was reserved at SOP, so the FIFO cannot fill with uncommitted data and deadlock.
- **Output side:** `out_tvalid` is high while `rd_ptr != commit_ptr` and the output register holds a beat. `rd_ptr` advances on out_tvalid && out_tready. Output data is exactly the stored beat, bit-for-bit.
- **Arithmetic:**
  - Pointers are DEPTH_LOG2+1 bits wide; the MSB is the wrap bit.
  - Empty: `rd_ptr == commit_ptr`.
  - Occupancy is computed modulo 2^(DEPTH_LOG2+1).
- **Counters:** each counter increments by at most 1 per cycle and holds at 16'hFFFF.

## Timing
- **Reset values:** m_axis_rx_tready 0, out_tvalid 0, out_tdata/out_tkeep/out_tlast 0, pass_cnt 0, drop_cnt 0. All pointers are 0 and the FSM is in IDLE.
- m_axis_rx_tready first goes high on the cycle after user_reset deasserts.
- **Latency:** the tlast handshake in cycle N makes that TLP's first beat visible on out_tvalid at N+2 at the earliest (one cycle to commit, one cycle of registered RAM read). Subsequent beats follow one per cycle while out_tready is held high.
- **Throughput:** the input side accepts one beat per cycle; IDLE→SOP→STORE needs no bubble.
- When out_tready is low, the output holds out_tdata, out_tkeep and out_tlast stable.
- **Simultaneous commit and read:** these are independent; committing in the same cycle as draining the last older beat does not lose or duplicate beats.
- **Reset mid-packet:** all state clears in the same cycle, uncommitted and committed beats are discarded, and out_tvalid is 0 on the next cycle.

## Test plan
- **MWr32 passes.** Stimulus: BAR0, length 1, 2 beats (DW0 = 32'h40000001, tkeep on the last beat = 8'hFF). Required: the 2 identical beats appear on the out_* port, pass_cnt = 1, drop_cnt = 0, first out_tvalid 2 cycles after the tlast handshake.
- **Non-matching TLPs dropped.** Stimulus: MRd32 (DW0 = 32'h00000001), then MWr32 with BAR1 hit (tuser[3] = 1), then MWr with length 33. Required: no out_tvalid, drop_cnt = 3, m_axis_rx_tready stays 1 throughout.
- **Forwarded error rolled back.** Stimulus: MWr64 of length 4 (4 beats) with tuser[1] = 1 on beat 3. Required: nothing output, drop_cnt = 1. A following good MWr32 is output as the first beat at out_*, proving wr_ptr was restored.
- **Backpressure and space reservation.** Stimulus: hold out_tready = 0, DEPTH_LOG2 = 5 (32 entries), then send 18-beat MWr64s with length 32. Required: the first TLP is accepted; tready drops at the second SOP (free = 14 < 18). Releasing out_tready drains 18 beats in order, and tready rises once free ≥ 18.
- **Saturation and reset.** Stimulus: preload pass_cnt near 16'hFFFF via 65540 passing TLPs. Required: pass_cnt holds at 16'hFFFF. Asserting user_reset mid-STORE then clears counters, outputs and FIFO on the next cycle, and the interrupted TLP is never output.
